router_fifo: RTL and testbench
==============================

ROUTER_FIFO -- requirements
Module: router_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, number of storage entries (power of two).
REQ-002 The block SHALL have parameter WIDTH, default 8, byte width of data_in/data_out.
REQ-003 The block SHALL have port clock  input  1  rising-edge clock for all state.
REQ-004 The block SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port soft_reset  input  1  synchronous flush from the channel's timeout logic.
REQ-006 The block SHALL have port write_enb  input  1  write request (one bit of the 3-bit channel write-enable vector).
REQ-007 The block SHALL have port read_enb  input  1  read request from the output-port reader.
REQ-008 The block SHALL have port lfd_state  input  1  marks the byte on data_in as a packet header.
REQ-009 The block SHALL have port data_in  input  WIDTH  packet byte to store.
REQ-010 The block SHALL have port data_out  output  WIDTH  registered read data, high-Z between packets.
REQ-011 The block SHALL have port full  output  1  no free entry; combinational from pointers.
REQ-012 The block SHALL have port empty  output  1  no stored entry; combinational from pointers; consumed as vld_out = ~empty.

Function
REQ-013 Storage SHALL be DEPTH entries of WIDTH+1 bits: {hdr_flag, byte}; hdr_flag = lfd_state at write.
REQ-014 Pointers wr_ptr, rd_ptr SHALL be log2(DEPTH)+1 bits (address + wrap bit), increment modulo 2*DEPTH.
REQ-015 empty SHALL be 1 when wr_ptr == rd_ptr; full SHALL be 1 when addresses equal and wrap bits differ.
REQ-016 Write: write_enb=1 and full=0 at a clock edge -> store {lfd_state, data_in} at wr_ptr, wr_ptr+1; write_enb with full=1 is dropped, no state change.
REQ-017 Read: read_enb=1 and empty=0 at a clock edge -> data_out <= stored byte at rd_ptr, rd_ptr+1; data_out valid one cycle after the accepting edge.
REQ-018 Packet counter pkt_count (7 bits): on a read of an entry with hdr_flag=1 SHALL load byte[7:2]+1 (payload length plus parity byte); on a read of a non-header entry with pkt_count!=0 SHALL decrement by 1.
REQ-019 On an edge with no accepted read: pkt_count==0 -> data_out <= 'z; pkt_count!=0 -> data_out holds.
REQ-020 Simultaneous read and write SHALL both proceed when full=0 and empty=0; when empty=1 only the write proceeds; when full=1 only the read proceeds (write dropped even though a slot frees that edge).
REQ-021 read_enb with empty=1 SHALL not move rd_ptr nor pkt_count; data_out follows REQ-019.
REQ-022 soft_reset=1 SHALL, at the next edge, clear wr_ptr, rd_ptr, pkt_count, drive data_out to 'z, and ignore write_enb/read_enb that cycle.
REQ-023 Priority at any edge SHALL be resetn > soft_reset > read/write.

Reset
REQ-024 resetn=0 at an edge SHALL set wr_ptr=0, rd_ptr=0, pkt_count=0, data_out=0, all storage entries=0; hence empty=1, full=0 the cycle after.
REQ-025 resetn asserted mid-packet SHALL discard all stored bytes and the partial packet count with no residual output.

Structure
REQ-026 Shared package router_pkg SHALL hold FIFO_DEPTH=16, DATA_W=8, PTR_W=5, HDR_LEN_MSB=7, HDR_LEN_LSB=2, CHANNELS=3.
REQ-027 The block SHALL be flat with no sub-module; three instances (channels 0..2) are made at router top.

Verification
REQ-028 Reset then write header 8'h0C (len 3, lfd_state=1) + 3 payload + 1 parity, read 5 times -> data_out 8'h0C then payload/parity in order, pkt_count 4->0, data_out='z on next idle edge, empty=1.
REQ-029 Write 16 bytes with no reads -> full=1 after 16th edge; 17th write dropped; read 16 -> exact original order, empty=1.
REQ-030 Full FIFO, read_enb=1 and write_enb=1 same edge -> one read, write dropped, full=0 afterwards, count 15.
REQ-031 4 bytes stored, assert soft_reset one cycle -> empty=1, data_out='z, subsequent read_enb yields no pointer movement.
REQ-032 Pointer wrap: 40 interleaved write/read pairs at depth 1..3 -> no loss, empty/full correct across wrap-bit toggles.
REQ-033 resetn=0 mid-packet (pkt_count=5) -> data_out=8'h00, empty=1, pkt_count=0 next cycle.

Source files
------------

// File: rtl/router_pkg.sv
// Shared constants for the router channel FIFOs and the router top.
package router_pkg;

  localparam int FIFO_DEPTH  = 16;
  localparam int DATA_W      = 8;
  localparam int PTR_W       = 5;
  localparam int HDR_LEN_MSB = 7;
  localparam int HDR_LEN_LSB = 2;
  localparam int CHANNELS    = 3;

  // Packet counter holds payload length (6 bits) plus one for the parity byte.
  localparam int PKT_W       = HDR_LEN_MSB - HDR_LEN_LSB + 2;

endpackage

// File: rtl/router_fifo.sv
// Per-channel packet FIFO. Each entry carries a header flag next to the byte
// so the read side can reload the packet counter when a header is read.
// data_out floats between packets: once the counter reaches zero and no read
// is accepted, the output driver is released.
module router_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int WIDTH = DATA_W
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int LEN_W = HDR_LEN_MSB - HDR_LEN_LSB + 1;

  logic [WIDTH:0]     mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [PKT_W-1:0]   pkt_count;
  logic [WIDTH-1:0]   data_q;
  logic               data_oe;
  logic               wr_ok;
  logic               rd_ok;
  logic [WIDTH:0]     rd_entry;
  logic [LEN_W-1:0]   hdr_len;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign wr_ok    = write_enb & ~full;
  assign rd_ok    = read_enb & ~empty;
  assign rd_entry = mem[rd_ptr[AW-1:0]];
  assign hdr_len  = rd_entry[HDR_LEN_MSB:HDR_LEN_LSB];
  assign data_out = data_oe ? data_q : 'z;

  // Storage: cleared on reset, written on accepted writes; soft reset only
  // rewinds the pointers, so stale entries are simply unreachable.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (!soft_reset && wr_ok) begin
      mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
    end
  end

  // Pointers, packet counter and registered read data.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pkt_count <= '0;
      data_q    <= '0;
      data_oe   <= 1'b1;
    end else if (soft_reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pkt_count <= '0;
      data_oe   <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        rd_ptr  <= rd_ptr + 1'b1;
        data_q  <= rd_entry[WIDTH-1:0];
        data_oe <= 1'b1;
        if (rd_entry[WIDTH])
          pkt_count <= PKT_W'(hdr_len) + PKT_W'(1);
        else if (pkt_count != '0)
          pkt_count <= pkt_count - 1'b1;
      end else if (pkt_count == '0) begin
        data_oe <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo against a queue-based packet model.
module tb_router_fifo;
  import router_pkg::*;

  localparam int DEPTH = FIFO_DEPTH;

  logic                clock = 1'b0;
  logic                resetn;
  logic                soft_reset;
  logic [CHANNELS-1:0] we_vec;
  logic                read_enb;
  logic                lfd_state;
  logic [DATA_W-1:0]   data_in;
  wire  [DATA_W-1:0]   data_out;
  wire                 full;
  wire                 empty;

  always #5 clock = ~clock;

  router_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_W)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .write_enb  (we_vec[0]),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .data_out   (data_out),
    .full       (full),
    .empty      (empty)
  );

  // Reference model: stored entries as a queue, plus output/counter state.
  logic [8:0] mq[$];
  int         m_pkt;
  logic [7:0] m_dout;
  bit         m_oe;
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic step(input bit rn, input bit sr, input bit we, input bit re,
                      input bit lfd, input logic [7:0] din);
    bit         rd;
    bit         wr;
    logic [8:0] e;
    resetn     = rn;
    soft_reset = sr;
    we_vec     = '0;
    we_vec[0]  = we;
    read_enb   = re;
    lfd_state  = lfd;
    data_in    = din;
    @(posedge clock);
    if (!rn) begin
      mq.delete(); m_pkt = 0; m_dout = 8'h00; m_oe = 1'b1;
    end else if (sr) begin
      mq.delete(); m_pkt = 0; m_oe = 1'b0;
    end else begin
      rd = re && (mq.size() != 0);
      wr = we && (mq.size() != DEPTH);
      if (rd) begin
        e = mq.pop_front();
        m_dout = e[7:0];
        m_oe   = 1'b1;
        if (e[8]) m_pkt = (int'(e[7:0]) / 4) + 1;
        else if (m_pkt > 0) m_pkt = m_pkt - 1;
      end else if (m_pkt == 0) begin
        m_oe = 1'b0;
      end
      if (wr) mq.push_back({lfd, din});
    end
    #1;
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 0, 8'h00);
    step(0, 0, 1, 1, 1, 8'hA5);
    n_checks++;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty actual=%b required=1", empty); end
    n_checks++;
    if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full actual=%b required=0", full); end
    n_checks++;
    if (dut.data_oe !== 1'b1 || data_out !== 8'h00)
      begin n_fail++; $display("FAIL reset_data actual=%h oe=%b required=00", data_out, dut.data_oe); end
    n_checks++;
    if (dut.pkt_count !== '0) begin n_fail++; $display("FAIL reset_pkt actual=%0d required=0", dut.pkt_count); end
  endtask

  task automatic test_packet();
    logic [7:0] pkt[5];
    step(0, 0, 0, 0, 0, 8'h00);
    pkt[0] = 8'h0C;
    pkt[4] = 8'h0C;
    for (int i = 1; i < 4; i++) begin
      pkt[i] = 8'($urandom);
      pkt[4] = pkt[4] ^ pkt[i];
    end
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0, (i == 0), pkt[i]);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 1, 0, 8'h00);
      n_checks++;
      if (dut.data_oe !== 1'b1 || data_out !== pkt[i])
        begin n_fail++; $display("FAIL packet_byte%0d actual=%h required=%h", i, data_out, pkt[i]); end
      n_checks++;
      if (int'(dut.pkt_count) !== 4 - i)
        begin n_fail++; $display("FAIL packet_count%0d actual=%0d required=%0d", i, dut.pkt_count, 4 - i); end
    end
    step(1, 0, 0, 0, 0, 8'h00);
    n_checks++;
    if (dut.data_oe !== 1'b0) begin n_fail++; $display("FAIL packet_idle_z actual_oe=%b required=0", dut.data_oe); end
    n_checks++;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL packet_empty actual=%b required=1", empty); end
  endtask

  task automatic fill(output logic [7:0] arr[DEPTH]);
    step(0, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < DEPTH; i++) begin
      arr[i] = 8'($urandom);
      step(1, 0, 1, 0, 0, arr[i]);
    end
  endtask

  task automatic test_full();
    logic [7:0] arr[DEPTH];
    fill(arr);
    n_checks++;
    if (full !== 1'b1 || empty !== 1'b0)
      begin n_fail++; $display("FAIL full_set actual full=%b empty=%b required full=1 empty=0", full, empty); end
    step(1, 0, 1, 0, 0, 8'h5A);
    n_checks++;
    if (full !== 1'b1) begin n_fail++; $display("FAIL full_drop actual=%b required=1", full); end
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, 0, 1, 0, 8'h00);
      n_checks++;
      if (data_out !== arr[i])
        begin n_fail++; $display("FAIL full_order%0d actual=%h required=%h", i, data_out, arr[i]); end
    end
    n_checks++;
    if (empty !== 1'b1 || full !== 1'b0)
      begin n_fail++; $display("FAIL full_drain actual empty=%b full=%b required empty=1 full=0", empty, full); end
  endtask

  task automatic test_full_rw();
    logic [7:0]       arr[DEPTH];
    logic [PTR_W-1:0] cnt;
    fill(arr);
    step(1, 0, 1, 1, 0, 8'hEE);
    cnt = dut.wr_ptr - dut.rd_ptr;
    n_checks++;
    if (data_out !== arr[0]) begin n_fail++; $display("FAIL fullrw_data actual=%h required=%h", data_out, arr[0]); end
    n_checks++;
    if (full !== 1'b0) begin n_fail++; $display("FAIL fullrw_full actual=%b required=0", full); end
    n_checks++;
    if (cnt !== PTR_W'(DEPTH - 1)) begin n_fail++; $display("FAIL fullrw_count actual=%0d required=%0d", cnt, DEPTH - 1); end
    for (int i = 1; i < DEPTH; i++) step(1, 0, 0, 1, 0, 8'h00);
    n_checks++;
    if (data_out !== arr[DEPTH-1] || empty !== 1'b1)
      begin n_fail++; $display("FAIL fullrw_drain actual=%h empty=%b required=%h empty=1", data_out, empty, arr[DEPTH-1]); end
  endtask

  task automatic test_soft_reset();
    step(0, 0, 0, 0, 0, 8'h00);
    step(1, 0, 1, 0, 1, 8'h14);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0, 8'($urandom));
    step(1, 0, 0, 1, 0, 8'h00);
    n_checks++;
    if (int'(dut.pkt_count) !== 6) begin n_fail++; $display("FAIL soft_pre_pkt actual=%0d required=6", dut.pkt_count); end
    step(1, 1, 1, 1, 0, 8'h33);
    n_checks++;
    if (empty !== 1'b1 || dut.data_oe !== 1'b0 || dut.pkt_count !== '0)
      begin n_fail++; $display("FAIL soft_clear actual empty=%b oe=%b pkt=%0d required 1 0 0", empty, dut.data_oe, dut.pkt_count); end
    step(1, 0, 0, 1, 0, 8'h00);
    n_checks++;
    if (dut.rd_ptr !== '0 || empty !== 1'b1 || dut.data_oe !== 1'b0)
      begin n_fail++; $display("FAIL soft_read actual rd_ptr=%0d empty=%b oe=%b required 0 1 0", dut.rd_ptr, empty, dut.data_oe); end
  endtask

  task automatic test_wrap();
    int pre;
    step(0, 0, 0, 0, 0, 8'h00);
    pre = $urandom_range(1, 3);
    for (int i = 0; i < pre; i++) step(1, 0, 1, 0, 0, 8'($urandom));
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        step(1, 0, 1, 1, 0, 8'($urandom));
      end else begin
        step(1, 0, 1, 0, 0, 8'($urandom));
        step(1, 0, 0, 1, 0, 8'h00);
      end
      n_checks++;
      if (empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH))
        begin n_fail++; $display("FAIL wrap_flags%0d actual empty=%b full=%b required size=%0d", i, empty, full, mq.size()); end
      n_checks++;
      if (dut.data_oe !== m_oe || (m_oe && data_out !== m_dout))
        begin n_fail++; $display("FAIL wrap_data%0d actual=%h oe=%b required=%h oe=%b", i, data_out, dut.data_oe, m_dout, m_oe); end
    end
  endtask

  task automatic test_random();
    bit rn, sr, lfd;
    step(0, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 400; i++) begin
      rn  = ($urandom_range(0, 99) != 0);
      sr  = ($urandom_range(0, 59) == 0);
      lfd = ($urandom_range(0, 9) == 0);
      step(rn, sr, ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0), lfd, 8'($urandom));
      n_checks++;
      if (empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH))
        begin n_fail++; $display("FAIL rand_flags%0d actual empty=%b full=%b required size=%0d", i, empty, full, mq.size()); end
      n_checks++;
      if (dut.data_oe !== m_oe || (m_oe && data_out !== m_dout))
        begin n_fail++; $display("FAIL rand_data%0d actual=%h oe=%b required=%h oe=%b", i, data_out, dut.data_oe, m_dout, m_oe); end
      n_checks++;
      if (int'(dut.pkt_count) !== m_pkt)
        begin n_fail++; $display("FAIL rand_pkt%0d actual=%0d required=%0d", i, dut.pkt_count, m_pkt); end
    end
  endtask

  task automatic test_reset_mid_packet();
    step(0, 0, 0, 0, 0, 8'h00);
    step(1, 0, 1, 0, 1, 8'h10);
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 0, 8'($urandom));
    step(1, 0, 0, 1, 0, 8'h00);
    n_checks++;
    if (int'(dut.pkt_count) !== 5) begin n_fail++; $display("FAIL midrst_pre_pkt actual=%0d required=5", dut.pkt_count); end
    step(0, 0, 1, 1, 0, 8'h77);
    n_checks++;
    if (dut.data_oe !== 1'b1 || data_out !== 8'h00)
      begin n_fail++; $display("FAIL midrst_data actual=%h oe=%b required=00", data_out, dut.data_oe); end
    n_checks++;
    if (empty !== 1'b1 || dut.pkt_count !== '0)
      begin n_fail++; $display("FAIL midrst_state actual empty=%b pkt=%0d required 1 0", empty, dut.pkt_count); end
    step(1, 0, 0, 1, 0, 8'h00);
    n_checks++;
    if (dut.data_oe !== 1'b0 || empty !== 1'b1)
      begin n_fail++; $display("FAIL midrst_residual actual oe=%b empty=%b required 0 1", dut.data_oe, empty); end
  endtask

  initial begin
    resetn = 1'b0; soft_reset = 1'b0; we_vec = '0; read_enb = 1'b0;
    lfd_state = 1'b0; data_in = '0;
    m_pkt = 0; m_dout = 8'h00; m_oe = 1'b1;
    #2;
    test_reset();
    test_packet();
    test_full();
    test_full_rw();
    test_soft_reset();
    test_wrap();
    test_reset_mid_packet();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
